// File: rtl/bit_select_packer.sv
// bit_select_packer: erasure-aware multi-lane bit selector packing decided bits into words.
// Optional BIT_SELECT_PACKER_ERASE_MASK_EN adds word_erased, a per-bit mask of hold-filled bits.
module bit_select_packer #(
  parameter int LANES  = 4,
  parameter int WORD_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2*LANES-1:0]   sym_in,
  input  logic                 sym_valid,
  output logic                 sym_ready,
  output logic [WORD_W-1:0]    word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     erasure_cnt,
`ifdef BIT_SELECT_PACKER_ERASE_MASK_EN
  output logic [WORD_W-1:0]    word_erased,
`endif
  output logic [LANES-1:0]     hold_bits
);
  localparam int BEATS = WORD_W / LANES;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int PW = $clog2(LANES + 1);
  localparam int SW = CNT_W + 1;
  typedef enum logic {FILL, STALL} state_t;
  state_t state, state_nx;
  logic [BW-1:0] beat_cnt;
  logic [WORD_W-1:0] asm_q, asm_nx;
  logic [LANES-1:0] er, bits;
  logic [PW-1:0] pop;
  logic [SW-1:0] sum;
  logic accept, last, drain, load_fill, load_stall;
  always_comb begin
    er = '0;
    bits = '0;
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      er[i] = &sym_in[2*i +: 2];
      bits[i] = er[i] ? hold_bits[i] : sym_in[2*i];
      pop = pop + PW'(er[i]);
    end
  end
  assign accept = sym_valid && sym_ready;
  assign last = beat_cnt == BW'(BEATS - 1);
  assign drain = word_valid && word_ready;
  assign load_fill = accept && last && (!word_valid || word_ready);
  assign load_stall = state == STALL && drain;
  assign sum = {1'b0, erasure_cnt} + SW'(pop);
  always_comb begin
    asm_nx = asm_q;
    asm_nx[int'(beat_cnt)*LANES +: LANES] = bits;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= FILL;
    else state <= state_nx;
  always_comb
    state_nx = state == FILL ? ((accept && last && word_valid && !word_ready) ? STALL : FILL)
                             : (drain ? FILL : STALL);
  // Gated by rst so the handshake reads 0 while reset is held.
  always_comb sym_ready = state == FILL && !en && rst;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      beat_cnt <= '0;
      asm_q <= '0;
      hold_bits <= '0;
      word_out <= '0;
      word_valid <= 1'b0;
      erasure_cnt <= '0;
    end else begin
      if (accept) begin
        asm_q <= asm_nx;
        hold_bits <= bits;
        beat_cnt <= last ? '0 : beat_cnt + 1'b1;
      end
      if (load_fill || load_stall) word_out <= load_fill ? asm_nx : asm_q;
      word_valid <= load_fill || load_stall || (word_valid && !word_ready);
      erasure_cnt <= cnt_clr ? '0 : !accept ? erasure_cnt : sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
`ifdef BIT_SELECT_PACKER_ERASE_MASK_EN
  logic [WORD_W-1:0] easm_q, easm_nx;
  always_comb begin
    easm_nx = easm_q;
    easm_nx[int'(beat_cnt)*LANES +: LANES] = er;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      easm_q <= '0;
      word_erased <= '0;
    end else begin
      if (accept) easm_q <= easm_nx;
      if (load_fill || load_stall) word_erased <= load_fill ? easm_nx : easm_q;
    end
`endif
endmodule

// File: tb/tb_bit_select_packer.sv
// tb_bit_select_packer: directed scenarios with a word scoreboard for bit_select_packer.
module tb_bit_select_packer;
  logic clk = 0, rst = 0, en = 0, sym_valid = 0, word_ready = 1, cnt_clr = 0;
  logic [7:0] sym_in = '0;
  logic sym_ready, word_valid;
  logic [15:0] word_out;
  logic [2:0] erasure_cnt;
  logic [3:0] hold_bits;
`ifdef BIT_SELECT_PACKER_ERASE_MASK_EN
  logic [15:0] word_erased;
`endif
  logic [15:0] exp_q[$], expm_q[$];
  int checks = 0, failures = 0;

  bit_select_packer #(.LANES(4), .WORD_W(16), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .cnt_clr(cnt_clr), .erasure_cnt(erasure_cnt),
`ifdef BIT_SELECT_PACKER_ERASE_MASK_EN
    .word_erased(word_erased),
`endif
    .hold_bits(hold_bits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] w, input logic [15:0] m);
    exp_q.push_back(w);
    expm_q.push_back(m);
  endtask

  task automatic send(input logic [7:0] s);
    int b = 0;
    @(posedge clk);
    #1 sym_in = s;
    sym_valid = 1;
    @(negedge clk);
    while (!sym_ready && b < 50) begin
      b++;
      @(negedge clk);
    end
    if (!sym_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 sym_valid = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  always @(negedge clk)
    if (rst && word_valid && word_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_word", 32'(word_out), 32'hdead);
      else begin
        chk("sb_word", 32'(word_out), 32'(exp_q.pop_front()));
`ifdef BIT_SELECT_PACKER_ERASE_MASK_EN
        chk("sb_mask", 32'(word_erased), 32'(expm_q.pop_front()));
`else
        void'(expm_q.pop_front());
`endif
      end
    end

  initial begin
    #2;
    chk("rst_valid", 32'(word_valid), 0);
    chk("rst_ready", 32'(sym_ready), 0);
    chk("rst_cnt", 32'(erasure_cnt), 0);
    do_reset();
    // Scenario 1: mixed beats with one all-erasure beat
    push(16'h500F, 16'h0F00);
    send(8'h55); send(8'h00); send(8'hFF); send(8'h11);
    chk("s1_latency", 32'(word_valid), 1);
    chk("s1_cnt", 32'(erasure_cnt), 4);
    chk("s1_hold", 32'(hold_bits), 32'b0101);
    // Scenario 2: backpressure into STALL
    do_reset();
    word_ready = 0;
    push(16'hF0F0, 16'h0000);
    push(16'h00FF, 16'h0000);
    send(8'h00); send(8'h55); send(8'h00); send(8'h55);
    send(8'h55); send(8'h55); send(8'h00); send(8'h00);
    chk("s2_stall_ready", 32'(sym_ready), 0);
    chk("s2_word1", 32'(word_out), 32'hF0F0);
    repeat (3) @(posedge clk);
    #1 chk("s2_word1_stable", 32'(word_out), 32'hF0F0);
    chk("s2_valid_held", 32'(word_valid), 1);
    word_ready = 1;
    @(posedge clk);
    #1 word_ready = 0;
    chk("s2_word2", 32'(word_out), 32'h00FF);
    chk("s2_valid2", 32'(word_valid), 1);
    chk("s2_ready_back", 32'(sym_ready), 1);
    @(posedge clk);
    #1 word_ready = 1;
    // Scenario 3: en freeze mid-word
    do_reset();
    push(16'hA5FF, 16'h0000);
    send(8'h55); send(8'h55);
    @(posedge clk);
    #1 en = 1;
    sym_in = 8'h00;
    sym_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s3_frozen_ready", 32'(sym_ready), 0);
      chk("s3_frozen_hold", 32'(hold_bits), 32'b1111);
    end
    @(posedge clk);
    #1 en = 0;
    sym_valid = 0;
    chk("s3_cnt", 32'(erasure_cnt), 0);
    send(8'h11); send(8'h44);
    // Scenario 4: saturation and clear
    do_reset();
    push(16'h0000, 16'hFFFF);
    push(16'h0000, 16'hFFFF);
    send(8'hFF);
    chk("s4_cnt1", 32'(erasure_cnt), 4);
    for (int i = 0; i < 8; i++) send(8'hFF);
    chk("s4_sat", 32'(erasure_cnt), 7);
    @(posedge clk);
    #1 cnt_clr = 1;
    sym_in = 8'hFF;
    sym_valid = 1;
    @(posedge clk);
    #1 cnt_clr = 0;
    sym_valid = 0;
    chk("s4_clr", 32'(erasure_cnt), 0);
    // Scenario 5: asynchronous reset mid-word
    do_reset();
    word_ready = 0;
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    send(8'h55); send(8'hFD);
    chk("s5_pre_cnt", 32'(erasure_cnt), 3);
    chk("s5_pre_valid", 32'(word_valid), 1);
    @(posedge clk);
    #3 rst = 0;
    #1 chk("s5_async_valid", 32'(word_valid), 0);
    chk("s5_async_cnt", 32'(erasure_cnt), 0);
    chk("s5_async_hold", 32'(hold_bits), 0);
    @(posedge clk);
    #1 rst = 1;
    word_ready = 1;
    push(16'h000F, 16'h0000);
    send(8'h55); send(8'h00); send(8'h00); send(8'h00);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1 chk("sb_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
